// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: WIDTH-bit add/subtract engine that reuses a single
// 4-bit carry-lookahead slice, one nibble per cycle, LSB nibble first.
// Valid/ready handshakes on the operand side and on the result side.
module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sub,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int NIB  = WIDTH / 4;
  localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;

  generate
    if (((WIDTH % 4) != 0) || (WIDTH < 4)) begin : g_bad_width
      $error("nibble_serial_adder: WIDTH must be a multiple of 4 and >= 4");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t            state;
  logic [WIDTH-1:0]  a_reg;
  logic [WIDTH-1:0]  b_reg;
  logic [WIDTH-1:0]  sum_reg;
  logic              carry;
  logic [IDXW-1:0]   idx;
  logic              a_msb;
  logic              b_msb;

  logic [3:0]        nib_a;
  logic [3:0]        nib_b;
  logic [3:0]        gen;
  logic [3:0]        prop;
  logic [4:0]        c;
  logic [3:0]        slice_sum;
  logic              slice_cout;
  logic [WIDTH-1:0]  next_sum;
  logic              last_nib;

  // Carry-lookahead slice on the current nibble, plus the partial sum with that nibble merged in
  always_comb begin
    nib_a     = a_reg[{idx, 2'b00} +: 4];
    nib_b     = b_reg[{idx, 2'b00} +: 4];
    gen       = nib_a & nib_b;
    prop      = nib_a ^ nib_b;
    c[0]      = carry;
    c[1]      = gen[0] | (prop[0] & c[0]);
    c[2]      = gen[1] | (prop[1] & gen[0]) | (prop[1] & prop[0] & c[0]);
    c[3]      = gen[2] | (prop[2] & gen[1]) | (prop[2] & prop[1] & gen[0])
              | (prop[2] & prop[1] & prop[0] & c[0]);
    c[4]      = gen[3] | (prop[3] & gen[2]) | (prop[3] & prop[2] & gen[1])
              | (prop[3] & prop[2] & prop[1] & gen[0])
              | (prop[3] & prop[2] & prop[1] & prop[0] & c[0]);
    slice_sum  = prop ^ c[3:0];
    slice_cout = c[4];
    next_sum   = sum_reg;
    next_sum[{idx, 2'b00} +: 4] = slice_sum;
    last_nib   = (idx == IDXW'(NIB - 1));
  end

  // Control FSM with registered handshake and result outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      carry     <= 1'b0;
      idx       <= '0;
      a_msb     <= 1'b0;
      b_msb     <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_cout  <= 1'b0;
      out_ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg    <= in_a;
            b_reg    <= in_b ^ {WIDTH{in_sub}};
            carry    <= in_sub;
            idx      <= '0;
            a_msb    <= in_a[WIDTH-1];
            b_msb    <= in_b[WIDTH-1] ^ in_sub;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          sum_reg <= next_sum;
          carry   <= slice_cout;
          if (last_nib) begin
            out_sum   <= next_sum;
            out_cout  <= slice_cout;
            out_ovf   <= (a_msb == b_msb) && (slice_sum[3] != a_msb);
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb_nibble_serial_adder: directed self-checking bench for the 16-bit
// nibble-serial add/subtract engine.
module tb_nibble_serial_adder;

  localparam int WIDTH = 16;
  localparam int NIB   = WIDTH / 4;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic             in_sub;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;

  int checks   = 0;
  int failures = 0;

  nibble_serial_adder #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sub    (in_sub),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf)
  );

  // Free-running clock, 10 time units per period
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input logic sub);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_sub   = sub;
    step();
  endtask

  task automatic waitResult(input string tag);
    int lat;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 40) begin
      step();
      lat++;
    end
    checkOutput({tag, "_latency"}, lat, NIB + 1);
  endtask

  task automatic runOp(input string tag, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b, input logic sub,
                       input logic [WIDTH-1:0] exp_sum, input logic exp_cout,
                       input logic exp_ovf);
    out_ready = 1'b1;
    applyStimulus(a, b, sub);
    in_valid = 1'b0;
    checkOutput({tag, "_busy"}, in_ready, 0);
    waitResult(tag);
    checkOutput({tag, "_sum"}, out_sum, exp_sum);
    checkOutput({tag, "_cout"}, out_cout, exp_cout);
    checkOutput({tag, "_ovf"}, out_ovf, exp_ovf);
    step();
    checkOutput({tag, "_ready_again"}, in_ready, 1);
    checkOutput({tag, "_valid_drop"}, out_valid, 0);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_sub    = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();

    checkOutput("rst_in_ready", in_ready, 1);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_sum", out_sum, 0);
    checkOutput("rst_out_cout", out_cout, 0);
    checkOutput("rst_out_ovf", out_ovf, 0);
    for (int i = 0; i < 10; i++) begin
      step();
      checkOutput("idle_in_ready", in_ready, 1);
      checkOutput("idle_out_valid", out_valid, 0);
    end

    runOp("add_chain", 16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0);
    runOp("add_ripple", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    runOp("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    runOp("sub_neg", 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    runOp("sub_ovf", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);

    // Backpressure: result held while consumer stalls; a second request waits
    out_ready = 1'b0;
    applyStimulus(16'h00A5, 16'h0F0F, 1'b0);
    in_valid = 1'b1;
    in_a     = 16'h1111;
    in_b     = 16'h2222;
    in_sub   = 1'b0;
    checkOutput("bp_busy", in_ready, 0);
    waitResult("bp_first");
    checkOutput("bp_first_sum", out_sum, 16'h0FB4);
    for (int i = 0; i < 7; i++) begin
      step();
      checkOutput("bp_hold_valid", out_valid, 1);
      checkOutput("bp_hold_sum", out_sum, 16'h0FB4);
      checkOutput("bp_hold_cout", out_cout, 0);
      checkOutput("bp_hold_not_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checkOutput("bp_idle_ready", in_ready, 1);
    checkOutput("bp_idle_valid", out_valid, 0);
    checkOutput("bp_idle_sum_kept", out_sum, 16'h0FB4);
    step();
    in_valid = 1'b0;
    checkOutput("bp_second_busy", in_ready, 0);
    waitResult("bp_second");
    checkOutput("bp_second_sum", out_sum, 16'h3333);
    checkOutput("bp_second_cout", out_cout, 0);
    checkOutput("bp_second_ovf", out_ovf, 0);
    out_ready = 1'b1;
    step();
    checkOutput("bp_second_ready_again", in_ready, 1);

    // Reset on the second RUN cycle aborts the operation
    applyStimulus(16'h1234, 16'h1111, 1'b0);
    in_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checkOutput("mid_rst_in_ready", in_ready, 1);
    checkOutput("mid_rst_out_valid", out_valid, 0);
    checkOutput("mid_rst_out_sum", out_sum, 0);
    for (int i = 0; i < 8; i++) begin
      step();
      checkOutput("mid_rst_no_result", out_valid, 0);
    end
    runOp("after_rst", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
